// File: rtl/gmac_pkg.sv
// Shared MAC definitions: transmit FSM encoding, preamble/SFD bytes,
// default sizing constants and the byte-wide Ethernet CRC helpers.
package gmac_pkg;

    // Transmit FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PAD      = 3'd3;
    localparam logic [2:0] ST_FCS      = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;
    localparam logic [2:0] ST_IFG      = 3'd6;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int IFG_BYTES_DEFAULT = 12;
    localparam int MIN_FRAME_DEFAULT = 60;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    // Advance the reflected CRC-32 register by one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Select one FCS byte in wire order (byte 0 = fcs[7:0])
    function automatic logic [7:0] fcs_byte(input logic [31:0] fcs,
                                            input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = fcs[7:0];
            2'd1:    b = fcs[15:8];
            2'd2:    b = fcs[23:16];
            2'd3:    b = fcs[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc32_ethernet_byte.sv
// Byte-wide Ethernet CRC-32 accumulator. crc_state is the raw register
// (residue 32'hDEBB20E3 after a good frame plus its FCS); fcs is the
// complemented value to transmit, least significant byte first.
module crc32_ethernet_byte
    import gmac_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        data_valid,
    input  logic [7:0]  data,
    output logic [31:0] crc_state,
    output logic [31:0] fcs
);

    logic [31:0] crc_r;

    // CRC register: preset on init, advanced on each valid byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_r <= CRC_INIT;
        end else if (init) begin
            crc_r <= CRC_INIT;
        end else if (data_valid) begin
            crc_r <= crc32_byte(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_state = crc_r;
    assign fcs       = ~crc_r;

endmodule

// File: rtl/tx_engine.sv
// GMII transmit engine: preamble/SFD insertion, optional short-frame
// padding, FCS append, underrun handling and inter-frame gap.
// Optional feature macro: TX_PAD_EN (zero-pad frames below MIN_FRAME).
module tx_engine
    import gmac_pkg::*;
#(
    parameter int IFG_BYTES = IFG_BYTES_DEFAULT,
    parameter int MIN_FRAME = MIN_FRAME_DEFAULT
) (
    input  logic       gmii_tx_clk,
    input  logic       rstn,
    input  logic       cfg_tx_en,
    input  logic       fifo_rd_valid,
    output logic       fifo_rd_ready,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_rd_last,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [7:0]  IFG_LAST    = 8'(IFG_BYTES - 1);
    localparam logic [15:0] MIN_FRAME_W = 16'(MIN_FRAME);

    logic [2:0]  state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [15:0] byte_cnt_r, byte_cnt_nxt_s;
    logic [31:0] fcs_r, fcs_nxt_s;

    logic [7:0]  txd_nxt_s;
    logic        tx_en_nxt_s;
    logic        tx_er_nxt_s;
    logic        done_nxt_s;
    logic        underrun_nxt_s;

    logic        crc_init_s;
    logic        crc_valid_s;
    logic [7:0]  crc_data_s;
    logic [31:0] crc_state_s;
    logic [31:0] crc_fcs_s;
    logic        crc_state_unused_s;

    crc32_ethernet_byte u_crc (
        .clk        (gmii_tx_clk),
        .rstn       (rstn),
        .init       (crc_init_s),
        .data_valid (crc_valid_s),
        .data       (crc_data_s),
        .crc_state  (crc_state_s),
        .fcs        (crc_fcs_s)
    );

    // The raw register is only of interest to the receive-side residue check
    assign crc_state_unused_s = ^crc_state_s;

    // The FIFO is read while sending data and while discarding after underrun
    assign fifo_rd_ready = (state_r == ST_DATA) || (state_r == ST_DRAIN);

    // Next-state, counter and next-output decisions for the transmit FSM
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        byte_cnt_nxt_s = byte_cnt_r;
        fcs_nxt_s      = fcs_r;
        txd_nxt_s      = 8'h00;
        tx_en_nxt_s    = 1'b0;
        tx_er_nxt_s    = 1'b0;
        done_nxt_s     = 1'b0;
        underrun_nxt_s = 1'b0;
        crc_init_s     = 1'b0;
        crc_valid_s    = 1'b0;
        crc_data_s     = 8'h00;

        case (state_r)
            ST_IDLE: begin
                if (cfg_tx_en && fifo_rd_valid) begin
                    state_nxt_s = ST_PREAMBLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                tx_en_nxt_s = 1'b1;
                if (cnt_r == 8'd7) begin
                    txd_nxt_s      = SFD_BYTE;
                    crc_init_s     = 1'b1;
                    cnt_nxt_s      = 8'd0;
                    byte_cnt_nxt_s = 16'd0;
                    state_nxt_s    = ST_DATA;
                end else begin
                    txd_nxt_s = PREAMBLE_BYTE;
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end

            ST_DATA: begin
                tx_en_nxt_s = 1'b1;
                if (fifo_rd_valid) begin
                    txd_nxt_s   = fifo_rd_data;
                    crc_valid_s = 1'b1;
                    crc_data_s  = fifo_rd_data;
                    if (byte_cnt_r < MIN_FRAME_W) begin
                        byte_cnt_nxt_s = byte_cnt_r + 16'd1;
                    end else begin
                        byte_cnt_nxt_s = byte_cnt_r;
                    end
                    if (fifo_rd_last) begin
                        cnt_nxt_s = 8'd0;
`ifdef TX_PAD_EN
                        if ((byte_cnt_r + 16'd1) < MIN_FRAME_W) begin
                            state_nxt_s = ST_PAD;
                        end else begin
                            state_nxt_s = ST_FCS;
                        end
`else
                        state_nxt_s = ST_FCS;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    // Starved mid-frame: mark the frame bad on the wire, then discard
                    tx_er_nxt_s    = 1'b1;
                    underrun_nxt_s = 1'b1;
                    state_nxt_s    = ST_DRAIN;
                end
            end

`ifdef TX_PAD_EN
            ST_PAD: begin
                tx_en_nxt_s    = 1'b1;
                crc_valid_s    = 1'b1;
                byte_cnt_nxt_s = byte_cnt_r + 16'd1;
                if ((byte_cnt_r + 16'd1) >= MIN_FRAME_W) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_FCS;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
`endif

            ST_FCS: begin
                tx_en_nxt_s = 1'b1;
                if (cnt_r == 8'd0) begin
                    // CRC register is final now; hold the value for bytes 1..3
                    fcs_nxt_s = crc_fcs_s;
                    txd_nxt_s = crc_fcs_s[7:0];
                end else begin
                    txd_nxt_s = fcs_byte(fcs_r, cnt_r[1:0]);
                end
                if (cnt_r == 8'd3) begin
                    done_nxt_s  = 1'b1;
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_IFG;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end

            ST_DRAIN: begin
                if (fifo_rd_valid && fifo_rd_last) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_IFG;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end

            ST_IFG: begin
                if (cnt_r == IFG_LAST) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end

            default: begin
                cnt_nxt_s   = 8'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and counters
    always_ff @(posedge gmii_tx_clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            byte_cnt_r <= 16'd0;
            fcs_r      <= 32'h00000000;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            fcs_r      <= fcs_nxt_s;
        end
    end

    // Registered GMII pins and status pulses
    always_ff @(posedge gmii_tx_clk or negedge rstn) begin
        if (!rstn) begin
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
            gmii_tx_er  <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            gmii_txd    <= txd_nxt_s;
            gmii_tx_en  <= tx_en_nxt_s;
            gmii_tx_er  <= tx_er_nxt_s;
            tx_done     <= done_nxt_s;
            tx_underrun <= underrun_nxt_s;
        end
    end

endmodule

// File: tb/tb_tx_engine.sv
// Scoreboard bench for tx_engine: stimulus queues FIFO bytes and the
// expected wire bytes / frame summaries; a monitor compares on the wire.
module tb_tx_engine;

    localparam int IFG = 12;
    localparam int MINF = 60;

    logic       gmii_tx_clk = 1'b0;
    logic       rstn;
    logic       cfg_tx_en;
    logic       fifo_rd_valid;
    logic       fifo_rd_ready;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_last;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       tx_done;
    logic       tx_underrun;

    tx_engine #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
        .gmii_tx_clk   (gmii_tx_clk),
        .rstn          (rstn),
        .cfg_tx_en     (cfg_tx_en),
        .fifo_rd_valid (fifo_rd_valid),
        .fifo_rd_ready (fifo_rd_ready),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_last  (fifo_rd_last),
        .gmii_txd      (gmii_txd),
        .gmii_tx_en    (gmii_tx_en),
        .gmii_tx_er    (gmii_tx_er),
        .tx_done       (tx_done),
        .tx_underrun   (tx_underrun)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    typedef struct {logic [7:0] d; logic last; int gap;} src_t;
    typedef struct {logic [7:0] txd; logic er; logic done; logic und;} exp_t;
    typedef struct {int len; bit chk; int gap;} frm_t;

    src_t src_q[$];
    exp_t exp_q[$];
    frm_t frm_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int frames_done = 0;
    int frames_started = 0;
    int acc_total = 0;
    logic hs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent bit-serial reflected CRC-32
    function automatic logic [31:0] tb_crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic exp_push(input logic [7:0] b, input logic er, input logic done, input logic und);
        exp_t e;
        e.txd = b; e.er = er; e.done = done; e.und = und;
        exp_q.push_back(e);
    endtask

    // Queue one frame into the FIFO model and its expected wire image.
    // stall_at >= 0: valid drops for one cycle before byte index stall_at.
    task automatic push_frame(input int n, input int seed, input int stall_at, input int exp_gap);
        logic [31:0] c;
        logic [7:0]  b;
        int body;
        src_t s;
        frm_t f;
        for (int i = 0; i < 7; i++) exp_push(8'h55, 1'b0, 1'b0, 1'b0);
        exp_push(8'hD5, 1'b0, 1'b0, 1'b0);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'(seed * 16 + i * 7 + 3);
            s.d = b; s.last = (i == n - 1); s.gap = (i == stall_at) ? 1 : 0;
            src_q.push_back(s);
            if (stall_at < 0 || i < stall_at) begin
                exp_push(b, 1'b0, 1'b0, 1'b0);
                c = tb_crc_step(c, b);
            end
        end
        if (stall_at >= 0) begin
            exp_push(8'h00, 1'b1, 1'b0, 1'b1);
            f.len = 8 + stall_at + 1; f.chk = 1'b0; f.gap = exp_gap;
        end else begin
            body = n;
`ifdef TX_PAD_EN
            while (body < MINF) begin
                exp_push(8'h00, 1'b0, 1'b0, 1'b0);
                c = tb_crc_step(c, 8'h00);
                body++;
            end
`endif
            c = ~c;
            for (int k = 0; k < 4; k++) exp_push(c[8*k +: 8], 1'b0, (k == 3), 1'b0);
            f.len = 8 + body + 4; f.chk = 1'b1; f.gap = exp_gap;
        end
        frm_q.push_back(f);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        for (int k = 0; k < budget && frames_done < target; k++) @(posedge gmii_tx_clk);
        if (frames_done < target) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout, frames_done=%0d expected %0d", name, frames_done, target);
        end
    endtask

    // Handshake sampled mid-cycle, when valid and ready are both stable
    initial begin : hs_sample
        forever begin
            @(negedge gmii_tx_clk);
            hs = fifo_rd_valid && fifo_rd_ready;
        end
    end

    // FIFO read-port model
    initial begin : drv
        int gap_cnt;
        gap_cnt = 0;
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = 8'h00;
        fifo_rd_last  = 1'b0;
        forever begin
            @(posedge gmii_tx_clk);
            #1;
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                acc_total++;
                gap_cnt = 0;
            end
            if (src_q.size() > 0 && gap_cnt < src_q[0].gap) begin
                fifo_rd_valid = 1'b0;
                gap_cnt++;
            end else if (src_q.size() > 0) begin
                fifo_rd_valid = 1'b1;
                fifo_rd_data  = src_q[0].d;
                fifo_rd_last  = src_q[0].last;
            end else begin
                fifo_rd_valid = 1'b0;
                fifo_rd_last  = 1'b0;
            end
        end
    end

    // Wire monitor: per-byte compare, frame length, FCS residue, gap
    initial begin : mon
        int run_len, idle_cnt, run_gap;
        logic [31:0] resid;
        exp_t e;
        frm_t f;
        run_len = 0; idle_cnt = 0; run_gap = 0; resid = 32'hFFFFFFFF;
        forever begin
            @(negedge gmii_tx_clk);
            if (!rstn) begin
                run_len = 0;
                idle_cnt = 0;
            end else if (gmii_tx_en) begin
                if (run_len == 0) begin
                    run_gap = idle_cnt;
                    resid = 32'hFFFFFFFF;
                    frames_started++;
                end
                if (run_len >= 8) resid = tb_crc_step(resid, gmii_txd);
                run_len++;
                if (exp_q.size() == 0) begin
                    check("wire_unexpected_byte", {56'd0, gmii_txd}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wire_txd_er_done_und",
                          {53'd0, gmii_txd, gmii_tx_er, tx_done, tx_underrun},
                          {53'd0, e.txd, e.er, e.done, e.und});
                end
            end else begin
                check("idle_er_done_und", {61'd0, gmii_tx_er, tx_done, tx_underrun}, 64'd0);
                if (run_len > 0) begin
                    if (frm_q.size() == 0) begin
                        check("frame_unexpected", 64'(run_len), 64'd0);
                    end else begin
                        f = frm_q.pop_front();
                        check("frame_len", 64'(run_len), 64'(f.len));
                        if (f.chk) check("fcs_residue", {32'd0, resid}, 64'hDEBB20E3);
                        if (f.gap >= 0) check("ifg_gap", 64'(run_gap), 64'(f.gap));
                    end
                    frames_done++;
                    run_len = 0;
                    idle_cnt = 0;
                end
                idle_cnt++;
            end
        end
    end

    initial begin : stim
        int base, fs, fd;
        bit hit;
        cfg_tx_en = 1'b1;
        rstn = 1'b1;
        #3 rstn = 1'b0;
        #2;
        check("rst_txd", {56'd0, gmii_txd}, 64'h00);
        check("rst_tx_en", {63'd0, gmii_tx_en}, 64'd0);
        check("rst_tx_er", {63'd0, gmii_tx_er}, 64'd0);
        check("rst_done", {63'd0, tx_done}, 64'd0);
        check("rst_underrun", {63'd0, tx_underrun}, 64'd0);
        check("rst_ready", {63'd0, fifo_rd_ready}, 64'd0);
        repeat (3) @(posedge gmii_tx_clk);
        #2 rstn = 1'b1;

        // 60-byte frame, 72 cycles on the wire
        push_frame(60, 1, -1, -1);
        wait_frames(1, 400, "wait_f60");

        // 14-byte frame: 72 cycles padded, 26 otherwise
        push_frame(14, 2, -1, -1);
        wait_frames(2, 400, "wait_f14");

        // Underrun after byte 20 of 100; remainder drained silently
        push_frame(100, 3, 20, -1);
        wait_frames(3, 400, "wait_underrun");

        // Back-to-back 64-byte frames: IFG+1 idle cycles between them
        push_frame(64, 4, -1, -1);
        push_frame(64, 5, -1, IFG + 1);
        wait_frames(5, 800, "wait_b2b");

        // cfg_tx_en dropped at data byte 10: current frame completes, next waits
        repeat (20) @(posedge gmii_tx_clk);
        base = acc_total;
        fd = frames_done;
        push_frame(40, 6, -1, -1);
        for (int k = 0; k < 200 && acc_total < base + 10; k++) @(posedge gmii_tx_clk);
        #2 cfg_tx_en = 1'b0;
        push_frame(30, 7, -1, -1);
        wait_frames(fd + 1, 400, "wait_cfg_frame");
        fs = frames_started;
        repeat (100) @(posedge gmii_tx_clk);
        check("no_start_when_disabled", 64'(frames_started), 64'(fs));
        check("fifo_untouched_when_disabled", 64'(src_q.size()), 64'd30);
        #2 cfg_tx_en = 1'b1;
        wait_frames(fd + 2, 400, "wait_cfg_resume");

        // Asynchronous reset during FCS
        fd = frames_done;
        push_frame(60, 8, -1, -1);
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(posedge gmii_tx_clk);
            #2;
            if (exp_q.size() == 2) hit = 1'b1;
        end
        check("reached_fcs", {63'd0, hit}, 64'd1);
        rstn = 1'b0;
        #1;
        check("arst_tx_en", {63'd0, gmii_tx_en}, 64'd0);
        check("arst_txd", {56'd0, gmii_txd}, 64'h00);
        check("arst_tx_er_done_und", {61'd0, gmii_tx_er, tx_done, tx_underrun}, 64'd0);
        check("arst_ready", {63'd0, fifo_rd_ready}, 64'd0);
        exp_q.delete();
        frm_q.delete();
        repeat (3) @(posedge gmii_tx_clk);
        #2 rstn = 1'b1;
        push_frame(60, 9, -1, -1);
        wait_frames(fd + 1, 400, "wait_after_reset");

        repeat (5) @(posedge gmii_tx_clk);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("frame_queue_empty", 64'(frm_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
